// File: rtl/render_frame_sched_pkg.sv
// render_pkg: shared constants, object indices, scheduler state encoding and
// the framebuffer bounds helper used by the render frame scheduler.
package render_pkg;

  localparam int PX_WIDTH    = 160;
  localparam int PX_HEIGHT   = 120;
  localparam int N_OBJ       = 5;
  localparam int IDLE_MAX    = 1000000;
  localparam int OBJ_TIMEOUT = 65535;

  localparam int                 COLOR_W  = 3;
  localparam logic [COLOR_W-1:0] BG_COLOR = 3'b000;

  // Draw order inside a frame: the four squares, then the player on top.
  localparam logic [2:0] OBJ_SQ0 = 3'd0;
  localparam logic [2:0] OBJ_SQ1 = 3'd1;
  localparam logic [2:0] OBJ_SQ2 = 3'd2;
  localparam logic [2:0] OBJ_SQ3 = 3'd3;
  localparam logic [2:0] OBJ_PL  = 3'd4;

  typedef enum logic [2:0] {
    ST_CLEAR      = 3'd0,
    ST_START_OBJ  = 3'd1,
    ST_WAIT_OBJ   = 3'd2,
    ST_FRAME_DONE = 3'd3,
    ST_IDLE       = 3'd4
  } state_t;

  // True when a signed pixel coordinate lies inside a w x h framebuffer.
  function automatic logic in_bounds(input logic signed [15:0] x,
                                     input logic signed [15:0] y,
                                     input int w, input int h);
    return (int'(x) >= 0) && (int'(x) < w) && (int'(y) >= 0) && (int'(y) < h);
  endfunction

endpackage

// File: rtl/render_frame_sched_if.sv
// render_frame_sched_if: draw-engine handshake plus framebuffer write port.
// master = scheduler side, slave = engines/memory side.
interface render_frame_sched_if;
  import render_pkg::*;

  logic                      obj_start;
  logic [2:0]                obj_sel;
  logic                      obj_done;
  logic                      eng_wr;
  logic signed [15:0]        eng_x;
  logic signed [15:0]        eng_y;
  logic [COLOR_W-1:0]        eng_color;
  logic                      mem_we;
  logic [15:0]               mem_addr;
  logic [COLOR_W-1:0]        mem_data;

  modport master (
    output obj_start, obj_sel, mem_we, mem_addr, mem_data,
    input  obj_done, eng_wr, eng_x, eng_y, eng_color
  );

  modport slave (
    input  obj_start, obj_sel, mem_we, mem_addr, mem_data,
    output obj_done, eng_wr, eng_x, eng_y, eng_color
  );

endinterface

// File: rtl/render_frame_sched_fb_addr_gen.sv
// fb_addr_gen: one registered stage that bounds-checks a pixel request and
// turns it into a linear framebuffer address (y*W + x, plus the back-buffer
// offset when back is set). Out-of-range pixels never reach the memory.
module fb_addr_gen #(
  parameter int PX_WIDTH  = render_pkg::PX_WIDTH,
  parameter int PX_HEIGHT = render_pkg::PX_HEIGHT
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req,
  input  logic signed [15:0]             x,
  input  logic signed [15:0]             y,
  input  logic [render_pkg::COLOR_W-1:0] color,
  input  logic                           back,
  output logic                           we,
  output logic [15:0]                    addr,
  output logic [render_pkg::COLOR_W-1:0] data
);
  import render_pkg::*;

  localparam logic [15:0] FB_WORDS = 16'(PX_WIDTH * PX_HEIGHT);
  localparam logic [15:0] ROW_LEN  = 16'(PX_WIDTH);

  logic        hit_s;
  logic [15:0] lin_s;

  // Bounds check and linear address; only meaningful when hit_s is set.
  always_comb begin
    hit_s = req & in_bounds(x, y, PX_WIDTH, PX_HEIGHT);
    if (back) begin
      lin_s = y * ROW_LEN + x + FB_WORDS;
    end else begin
      lin_s = y * ROW_LEN + x;
    end
  end

  // Output register; address/data hold their last value between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we   <= 1'b0;
      addr <= 16'd0;
      data <= BG_COLOR;
    end else begin
      we <= hit_s;
      if (hit_s) begin
        addr <= lin_s;
        data <= color;
      end
    end
  end

endmodule

// File: rtl/render_frame_sched.sv
// render_frame_sched: per-frame sequencer CLEAR -> objects 0..N_OBJ-1 ->
// FRAME_DONE -> IDLE. Owns the framebuffer write port: background fill during
// CLEAR, bounds-checked forwarding of the granted engine's pixels otherwise.
// Build option: define RENDER_DBUF_EN for double buffering (buf_sel flips
// each frame, writes go to the back buffer at offset W*H).
module render_frame_sched #(
  parameter int PX_WIDTH    = render_pkg::PX_WIDTH,
  parameter int PX_HEIGHT   = render_pkg::PX_HEIGHT,
  parameter int N_OBJ       = render_pkg::N_OBJ,
  parameter int IDLE_MAX    = render_pkg::IDLE_MAX,
  parameter int OBJ_TIMEOUT = render_pkg::OBJ_TIMEOUT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  render_frame_sched_if.master        bus,
  output logic                        frame_busy,
  output logic                        frame_done,
  output logic [15:0]                 frame_cnt,
  output logic                        obj_err,
  output logic                        buf_sel
);
  import render_pkg::*;

  localparam int                TO_W      = $clog2(OBJ_TIMEOUT + 1);
  localparam int                IDLE_W    = $clog2(IDLE_MAX + 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(OBJ_TIMEOUT - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_MAX);
  localparam logic [15:0]       X_LAST    = 16'(PX_WIDTH - 1);
  localparam logic [15:0]       Y_LAST    = 16'(PX_HEIGHT - 1);
  localparam logic [2:0]        SEL_LAST  = 3'(N_OBJ - 1);

  state_t              state_r, state_n;
  logic [1:0]          rst_sync_r;
  logic                rst_int_n;
  logic [15:0]         clr_x_r, clr_y_r;
  logic [TO_W-1:0]     wait_cnt_r;
  logic [IDLE_W-1:0]   idle_cnt_r;
  logic [2:0]          obj_sel_r;
  logic                obj_start_r, frame_busy_r, frame_done_r, obj_err_r, buf_sel_r;
  logic [15:0]         frame_cnt_r;
  logic                clr_last_s, advance_s, timeout_s, back_s;
  logic                req_s;
  logic signed [15:0]  req_x_s, req_y_s;
  logic [COLOR_W-1:0]  req_color_s;
  logic                mem_we_s;
  logic [15:0]         mem_addr_s;
  logic [COLOR_W-1:0]  mem_data_s;

  // Reset synchroniser: asserts asynchronously, releases on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_r <= 2'b00;
    else        rst_sync_r <= {rst_sync_r[0], 1'b1};
  end
  assign rst_int_n = rst_sync_r[1];

  // State register.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) state_r <= ST_CLEAR;
    else            state_r <= state_n;
  end

  // Next-state logic, object advance (done or timeout) and pixel source mux.
  always_comb begin
    state_n     = state_r;
    advance_s   = 1'b0;
    timeout_s   = 1'b0;
    clr_last_s  = (clr_x_r == X_LAST) && (clr_y_r == Y_LAST);
    req_s       = 1'b0;
    req_x_s     = clr_x_r;
    req_y_s     = clr_y_r;
    req_color_s = BG_COLOR;
    case (state_r)
      ST_CLEAR: begin
        req_s = 1'b1;
        if (clr_last_s) state_n = ST_START_OBJ;
        else            state_n = ST_CLEAR;
      end
      ST_START_OBJ: state_n = ST_WAIT_OBJ;
      ST_WAIT_OBJ: begin
        req_s       = bus.eng_wr;
        req_x_s     = bus.eng_x;
        req_y_s     = bus.eng_y;
        req_color_s = bus.eng_color;
        if (bus.obj_done) begin
          advance_s = 1'b1;
        end else if (wait_cnt_r == TO_LAST) begin
          advance_s = 1'b1;
          timeout_s = 1'b1;
        end else begin
          advance_s = 1'b0;
        end
        if (!advance_s)                  state_n = ST_WAIT_OBJ;
        else if (obj_sel_r == SEL_LAST)  state_n = ST_FRAME_DONE;
        else                             state_n = ST_START_OBJ;
      end
      ST_FRAME_DONE: state_n = ST_IDLE;
      ST_IDLE: begin
        if ((idle_cnt_r == IDLE_LAST) && enable) state_n = ST_CLEAR;
        else                                     state_n = ST_IDLE;
      end
      default: state_n = ST_CLEAR;
    endcase
  end

  // Raster scan for the background fill, rewound whenever CLEAR is left.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      clr_x_r <= 16'd0;
      clr_y_r <= 16'd0;
    end else if (state_r != ST_CLEAR) begin
      clr_x_r <= 16'd0;
      clr_y_r <= 16'd0;
    end else if (clr_x_r == X_LAST) begin
      clr_x_r <= 16'd0;
      clr_y_r <= (clr_y_r == Y_LAST) ? 16'd0 : clr_y_r + 16'd1;
    end else begin
      clr_x_r <= clr_x_r + 16'd1;
    end
  end

  // Grant timer (per object) and inter-frame idle counter (saturating).
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      wait_cnt_r <= '0;
      idle_cnt_r <= '0;
    end else begin
      wait_cnt_r <= (state_r == ST_WAIT_OBJ && !advance_s) ? wait_cnt_r + 1'b1 : '0;
      if (state_r != ST_IDLE)         idle_cnt_r <= '0;
      else if (idle_cnt_r != IDLE_LAST) idle_cnt_r <= idle_cnt_r + 1'b1;
    end
  end

  // Object selection and registered status outputs, all derived from state_n.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      obj_sel_r    <= OBJ_SQ0;
      obj_start_r  <= 1'b0;
      frame_busy_r <= 1'b0;
      frame_done_r <= 1'b0;
      frame_cnt_r  <= 16'd0;
      obj_err_r    <= 1'b0;
    end else begin
      if (state_r == ST_WAIT_OBJ && state_n == ST_START_OBJ) obj_sel_r <= obj_sel_r + 3'd1;
      else if (state_r == ST_FRAME_DONE)                     obj_sel_r <= OBJ_SQ0;
      obj_start_r  <= (state_n == ST_START_OBJ);
      frame_busy_r <= (state_n == ST_CLEAR) || (state_n == ST_START_OBJ) ||
                      (state_n == ST_WAIT_OBJ);
      frame_done_r <= (state_n == ST_FRAME_DONE);
      if (state_n == ST_FRAME_DONE) frame_cnt_r <= frame_cnt_r + 16'd1;
      obj_err_r    <= obj_err_r | timeout_s;
    end
  end

`ifdef RENDER_DBUF_EN
  // Front/back swap at the end of every draw phase; draw into the back buffer.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n)                   buf_sel_r <= 1'b0;
    else if (state_n == ST_FRAME_DONE) buf_sel_r <= ~buf_sel_r;
  end
  assign back_s = ~buf_sel_r;
`else
  assign buf_sel_r = 1'b0;
  assign back_s    = 1'b0;
`endif

  fb_addr_gen #(
    .PX_WIDTH  (PX_WIDTH),
    .PX_HEIGHT (PX_HEIGHT)
  ) u_addr_gen (
    .clk   (clk),
    .rst_n (rst_int_n),
    .req   (req_s),
    .x     (req_x_s),
    .y     (req_y_s),
    .color (req_color_s),
    .back  (back_s),
    .we    (mem_we_s),
    .addr  (mem_addr_s),
    .data  (mem_data_s)
  );

  assign bus.obj_start = obj_start_r;
  assign bus.obj_sel   = obj_sel_r;
  assign bus.mem_we    = mem_we_s;
  assign bus.mem_addr  = mem_addr_s;
  assign bus.mem_data  = mem_data_s;
  assign frame_busy    = frame_busy_r;
  assign frame_done    = frame_done_r;
  assign frame_cnt     = frame_cnt_r;
  assign obj_err       = obj_err_r;
  assign buf_sel       = buf_sel_r;

endmodule

// File: tb/tb_render_frame_sched.sv
// tb_render_frame_sched: randomized engine stimulus with a queue scoreboard.
// Expected framebuffer writes, object grants and frame status are predicted
// from the pixel/bounds rules when stimulus is issued; a negedge monitor
// compares whatever the scheduler presents. Honours RENDER_DBUF_EN.
module tb_render_frame_sched;
  import render_pkg::*;

  localparam int W = 160, H = 120, NOBJ = 5, IDLE_M = 50, TO = 300;

  logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
  logic        frame_busy, frame_done, obj_err, buf_sel;
  logic [15:0] frame_cnt;

  render_frame_sched_if sif();

  render_frame_sched #(
    .PX_WIDTH(W), .PX_HEIGHT(H), .N_OBJ(NOBJ), .IDLE_MAX(IDLE_M), .OBJ_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bus(sif),
    .frame_busy(frame_busy), .frame_done(frame_done), .frame_cnt(frame_cnt),
    .obj_err(obj_err), .buf_sel(buf_sel)
  );

  always #5 clk = ~clk;

  logic [18:0] wr_q[$];   // {addr, data}
  logic [3:0]  st_q[$];   // {obj_err, obj_sel}
  logic [16:0] fd_q[$];   // {buf_sel, frame_cnt}
  int n_chk = 0, n_pass = 0, cyc = 0;
  int frames_model = 0;
  bit buf_model = 1'b0, err_model = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic summary();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  endtask

  function automatic int offset();
`ifdef RENDER_DBUF_EN
    return buf_model ? 0 : W * H;
`else
    return 0;
`endif
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push_clear(int n);
    for (int i = 0; i < n; i++) wr_q.push_back({16'(i + offset()), 3'b000});
  endtask

  task automatic drive(bit wr, int x, int y, int c, bit done);
    sif.eng_wr = wr; sif.eng_x = 16'(x); sif.eng_y = 16'(y);
    sif.eng_color = 3'(c); sif.obj_done = done;
  endtask

  // One engine cycle; an in-bounds strobe is expected at y*W+x one cycle later.
  task automatic eng_cycle(bit wr, int x, int y, int c, bit done);
    drive(wr, x, y, c, done);
    if (wr && x >= 0 && x < W && y >= 0 && y < H)
      wr_q.push_back({16'(y * W + x + offset()), 3'(c)});
    step();
    drive(1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic rand_cycle(bit done);
    eng_cycle(($urandom_range(0, 3) != 0), int'($urandom_range(0, 179)) - 10,
              int'($urandom_range(0, 139)) - 10, int'($urandom_range(0, 7)), done);
  endtask

  task automatic wait_start(int bound, output int t);
    int n = 0;
    while (!sif.obj_start && n < bound) begin step(); n++; end
    t = cyc;
    if (!sif.obj_start) begin
      check("obj_start_wait", 32'(sif.obj_start), 32'd1);
      summary();
    end
  endtask

  task automatic wait_frame_done(int bound);
    int n = 0;
    while (!frame_done && n < bound) begin step(); n++; end
    if (!frame_done) begin
      check("frame_done_wait", 32'(frame_done), 32'd1);
      summary();
    end
  endtask

  // Serve one granted object. Afterwards a stray write and done are driven in
  // the following (non-WAIT) cycle; both must be ignored.
  task automatic run_obj(int f, int o, output int t);
    wait_start(25000, t);
    step();
    drive(1'b0, 0, 0, 0, 1'b0);
    check("busy_in_wait", 32'(frame_busy), 32'd1);
    if (f == 0 && o == 0) begin
      eng_cycle(1'b1, 5, 2, 3, 1'b0);
      eng_cycle(1'b1, -1, 0, 1, 1'b0);
      eng_cycle(1'b1, 160, 0, 2, 1'b0);
      eng_cycle(1'b1, 0, 120, 4, 1'b0);
    end
    for (int i = 0; i < int'($urandom_range(3, 25)); i++) rand_cycle(1'b0);
    if (f == 0 && o == 2) return;
    if (f == 0 && o == 1) eng_cycle(1'b1, 10, 10, 5, 1'b1);
    else                  rand_cycle(1'b1);
    drive(1'b1, 1, 1, 7, 1'b1);
  endtask

  // Monitor: every presented output is matched against the scoreboard.
  initial begin
    logic [18:0] e;
    logic [3:0]  s;
    logic [16:0] fexp = '0;
    bit          fd_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (sif.mem_we) begin
          if (wr_q.size() == 0) check("mem_we_unexpected", 32'(sif.mem_we), 32'd0);
          else begin
            e = wr_q.pop_front();
            check("mem_write", {sif.mem_addr, sif.mem_data}, 32'(e));
          end
        end
        if (sif.obj_start) begin
          if (st_q.size() == 0) check("obj_start_unexpected", 32'(sif.obj_start), 32'd0);
          else begin
            s = st_q.pop_front();
            check("obj_start_sel_err", {obj_err, sif.obj_sel}, 32'(s));
          end
        end
        if (fd_pend) begin
          check("frame_status", {buf_sel, frame_cnt}, 32'(fexp));
          fd_pend = 1'b0;
        end
        if (frame_done) begin
          if (fd_q.size() == 0) check("frame_done_unexpected", 32'(frame_done), 32'd0);
          else begin fexp = fd_q.pop_front(); fd_pend = 1'b1; end
        end
      end
    end
  end

  initial forever begin @(posedge clk); cyc++; end

  initial begin
    #800000;
    check("watchdog_busy", 32'(frame_busy), 32'hdead);
    summary();
  end

  initial begin
    int t_st[NOBJ];
    drive(1'b0, 0, 0, 0, 1'b0);
    repeat (3) step();
    check("reset_bus", {sif.mem_we, sif.obj_start, sif.obj_sel, sif.mem_addr, sif.mem_data},
          32'd0);
    check("reset_status", {frame_busy, frame_done, frame_cnt, obj_err, buf_sel}, 32'd0);
    push_clear(W * H);
    rst_n = 1'b1; enable = 1'b1;

    for (int f = 0; f < 2; f++) begin
      for (int o = 0; o < NOBJ; o++) begin
        if (f == 1 && o == 2) enable = 1'b0;
        st_q.push_back({err_model, 3'(o)});
        run_obj(f, o, t_st[o]);
        if (f == 0 && o == 2) err_model = 1'b1;
      end
      frames_model++;
      buf_model = ~buf_model;
`ifndef RENDER_DBUF_EN
      buf_model = 1'b0;
`endif
      fd_q.push_back({buf_model, 16'(frames_model)});
      wait_frame_done(100);
      step();
      drive(1'b0, 0, 0, 0, 1'b0);
      if (f == 0) begin
        check("timeout_gap", 32'(t_st[3] - t_st[2]), 32'(TO + 1));
        push_clear(W * H);
      end
    end

    // enable was dropped mid-frame: frame finished, now parked in IDLE.
    repeat (3 * (IDLE_M + 1)) step();
    check("idle_not_busy", 32'(frame_busy), 32'd0);
    check("queues_drained", 32'(wr_q.size() + st_q.size() + fd_q.size()), 32'd0);
    check("idle_obj_sel", 32'(sif.obj_sel), 32'd0);

    push_clear(200);
    enable = 1'b1;
    step();
    check("restart_busy", 32'(frame_busy), 32'd1);
    for (int n = 0; n < 400 && wr_q.size() > 100; n++) step();
    check("restart_writes_seen", 32'(wr_q.size() <= 100), 32'd1);

    // Reset in the middle of a clear: the write port must drop at once.
    #2 rst_n = 1'b0;
    #1;
    check("midframe_reset",
          {sif.mem_we, sif.obj_start, frame_busy, frame_done, frame_cnt, obj_err, buf_sel},
          32'd0);
    wr_q.delete();
    summary();
  end

endmodule
